// File: rtl/dff_chk_pkg.sv
// Shared types and limits for the DFlipFlop response checker.
package dff_chk_pkg;
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_e;

  localparam int MAX_LATENCY    = 8;
  localparam int DEF_RUN_CYCLES = 800;
endpackage

// File: rtl/exp_delay_line.sv
// Golden model of the storage element: a LATENCY-deep shift register fed with
// the reset-masked D value, synchronously cleared to RST_VAL.
module exp_delay_line #(
  parameter int   LATENCY = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  input  logic dut_rst,
  output logic expected
);
  logic [LATENCY-1:0] stages;

  always_ff @(posedge clk) begin
    if (clr) begin
      stages <= {LATENCY{RST_VAL}};
    end else begin
      stages[0] <= dut_rst ? RST_VAL : d;
      for (int k = 1; k < LATENCY; k++) stages[k] <= stages[k-1];
    end
  end

  assign expected = stages[LATENCY-1];
endmodule

// File: rtl/dff_response_checker.sv
// Compares a storage-element DUT's Q against a delay-line model for a fixed
// number of cycles and reports error count, first failing index and pass.
module dff_response_checker
  import dff_chk_pkg::*;
#(
  parameter int   LATENCY    = 1,
  parameter int   RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int   CNT_W      = 32,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d,
  input  logic             dut_rst,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] first_err_cyc
);
  localparam int               FILL_W    = $clog2(MAX_LATENCY);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(RUN_CYCLES - 1);

  state_e            state, state_nx;
  logic [FILL_W-1:0] fill_cnt;
  logic              expected;
  logic              start_ok;
  logic              cmp_en;
  logic              mm_now;

  exp_delay_line #(.LATENCY(LATENCY), .RST_VAL(RST_VAL)) u_exp (
    .clk      (clk),
    .clr      (rst),
    .d        (d),
    .dut_rst  (dut_rst),
    .expected (expected)
  );

  assign start_ok = start && (state == IDLE || state == DONE);
  assign cmp_en   = (state == CHECK);
  assign mm_now   = cmp_en && (q != expected);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_nx = (LATENCY == 1) ? CHECK : FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (fill_cnt == FILL_LAST) state_nx = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (cyc_cnt == LAST_IDX) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results are registered: they reflect the compare of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt      <= '0;
      mismatch      <= 1'b0;
      err_cnt       <= '0;
      cyc_cnt       <= '0;
      first_err_cyc <= '0;
    end else begin
      mismatch <= 1'b0;
      if (start_ok) begin
        fill_cnt      <= '0;
        err_cnt       <= '0;
        cyc_cnt       <= '0;
        first_err_cyc <= '0;
      end
      if (state == FILL) fill_cnt <= fill_cnt + FILL_W'(1);
      if (cmp_en) begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (mm_now) begin
          mismatch <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) first_err_cyc <= cyc_cnt;
        end
      end
    end
  end

  assign pass = done && (err_cnt == '0);
endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench: four checker instances watch small behavioural DUTs; each
// run pushes its expected result, a monitor pops and compares on done rising.
module tb_dff_response_checker;
  typedef struct {
    logic pass;
    int   err;
    int   cyc;
    int   first;
    int   pulses;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v, d_v, dr_v, q_v;
  logic [3:0]  busy_v, done_v, pass_v, mm_v;
  logic [31:0] err_a, cyc_a, first_a, err_b, cyc_b, first_b;
  logic [4:0]  err_s, cyc_s, first_s, err_t, cyc_t, first_t;
  logic [31:0] err_v [4];
  logic [31:0] cyc_v [4];
  logic [31:0] first_v [4];

  logic        dq0, dq1, dq2, dq3;
  logic [2:0]  sh1;
  logic        ign0, three1, flip0;

  exp_t        sbq [4][$];
  int          pulses [4];
  logic [3:0]  done_q;
  int          n_chk, n_fail;

  always #5 clk = ~clk;

  dff_response_checker #(.LATENCY(1), .RUN_CYCLES(16), .CNT_W(32), .RST_VAL(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .d(d_v[0]), .dut_rst(dr_v[0]), .q(q_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .mismatch(mm_v[0]),
    .err_cnt(err_a), .cyc_cnt(cyc_a), .first_err_cyc(first_a));
  dff_response_checker #(.LATENCY(3), .RUN_CYCLES(16), .CNT_W(32), .RST_VAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .d(d_v[1]), .dut_rst(dr_v[1]), .q(q_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .mismatch(mm_v[1]),
    .err_cnt(err_b), .cyc_cnt(cyc_b), .first_err_cyc(first_b));
  dff_response_checker #(.LATENCY(1), .RUN_CYCLES(20), .CNT_W(5), .RST_VAL(1'b0)) u_s (
    .clk(clk), .rst(rst), .start(start_v[2]), .d(d_v[2]), .dut_rst(dr_v[2]), .q(q_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .mismatch(mm_v[2]),
    .err_cnt(err_s), .cyc_cnt(cyc_s), .first_err_cyc(first_s));
  dff_response_checker #(.LATENCY(1), .RUN_CYCLES(31), .CNT_W(5), .RST_VAL(1'b0)) u_t (
    .clk(clk), .rst(rst), .start(start_v[3]), .d(d_v[3]), .dut_rst(dr_v[3]), .q(q_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .mismatch(mm_v[3]),
    .err_cnt(err_t), .cyc_cnt(cyc_t), .first_err_cyc(first_t));

  always_comb begin
    err_v[0] = err_a;       cyc_v[0] = cyc_a;       first_v[0] = first_a;
    err_v[1] = err_b;       cyc_v[1] = cyc_b;       first_v[1] = first_b;
    err_v[2] = 32'(err_s);  cyc_v[2] = 32'(cyc_s);  first_v[2] = 32'(first_s);
    err_v[3] = 32'(err_t);  cyc_v[3] = 32'(cyc_t);  first_v[3] = 32'(first_t);
  end

  // Behavioural DUTs: inst0 one-stage (optionally ignoring reset, with a fault
  // flip), inst1 one- or three-stage, inst2/3 always inverted.
  always @(posedge clk) begin
    dq0 <= (dr_v[0] && !ign0) ? 1'b0 : d_v[0];
    dq1 <= d_v[1];
    sh1 <= {sh1[1:0], d_v[1]};
    dq2 <= d_v[2];
    dq3 <= d_v[3];
  end

  always_comb q_v = {~dq3, ~dq2, (three1 ? sh1[2] : dq1), dq0 ^ flip0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mm_v[i]) pulses[i]++;
      if (done_v[i] && !done_q[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("inst%0d unexpected done", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk($sformatf("inst%0d pass", i),          32'(pass_v[i]), 32'(e.pass));
          chk($sformatf("inst%0d err_cnt", i),       err_v[i],       32'(e.err));
          chk($sformatf("inst%0d cyc_cnt", i),       cyc_v[i],       32'(e.cyc));
          chk($sformatf("inst%0d first_err_cyc", i), first_v[i],     32'(e.first));
          chk($sformatf("inst%0d mismatch pulses", i), 32'(pulses[i]), 32'(e.pulses));
        end
        pulses[i] = 0;
      end
      done_q[i] = done_v[i];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk($sformatf("%s inst%0d busy", tag, i),     32'(busy_v[i]), 0);
    chk($sformatf("%s inst%0d done", tag, i),     32'(done_v[i]), 0);
    chk($sformatf("%s inst%0d pass", tag, i),     32'(pass_v[i]), 0);
    chk($sformatf("%s inst%0d mismatch", tag, i), 32'(mm_v[i]),   0);
    chk($sformatf("%s inst%0d err_cnt", tag, i),  err_v[i],       0);
    chk($sformatf("%s inst%0d cyc_cnt", tag, i),  cyc_v[i],       0);
    chk($sformatf("%s inst%0d first", tag, i),    first_v[i],     0);
  endtask

  // pat: 0 random, 1 constant 1, 2 1010.., 3 1100..; cycle 0 is the start cycle.
  task automatic run(input int i, input int lat, input int rn, input int pat,
                     input int flip_cyc, input int rst_cyc, input int pulse_cyc,
                     input exp_t e);
    sbq[i].push_back(e);
    for (int c = 0; c < lat + rn; c++) begin
      start_v[i] = (c == 0) || (c == pulse_cyc);
      case (pat)
        0:       d_v[i] = 1'($urandom);
        1:       d_v[i] = 1'b1;
        2:       d_v[i] = ~c[0];
        default: d_v[i] = ~c[1];
      endcase
      dr_v[i] = (rst_cyc >= 0) && (c >= rst_cyc) && (c < rst_cyc + 4);
      flip0   = (i == 0) && (c == flip_cyc);
      tick();
      if (c == 0) begin
        @(negedge clk);
        chk($sformatf("inst%0d busy after start", i), 32'(busy_v[i]), 1);
        chk($sformatf("inst%0d done after start", i), 32'(done_v[i]), 0);
        chk($sformatf("inst%0d err cleared", i),      err_v[i],       0);
        chk($sformatf("inst%0d cyc cleared", i),      cyc_v[i],       0);
        chk($sformatf("inst%0d first cleared", i),    first_v[i],     0);
      end
      if (pulse_cyc >= 0 && c == pulse_cyc + 1) begin
        @(negedge clk);
        chk($sformatf("inst%0d cyc after ignored start", i), cyc_v[i], 32'(c + 1 - lat));
      end
    end
    start_v[i] = 1'b0;
    dr_v[i]    = 1'b0;
    flip0      = 1'b0;
    @(negedge clk);
    chk($sformatf("inst%0d done at LATENCY+RUN_CYCLES", i), 32'(done_v[i]), 1);
    tick();
    tick();
  endtask

  initial begin
    exp_t e;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    done_q = '0;
    rst = 1'b1; start_v = '0; d_v = '0; dr_v = '0;
    ign0 = 1'b0; three1 = 1'b1; flip0 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_zero(i, "reset");
    tick();
    rst = 1'b0;
    tick();

    // Ideal DUT, random data.
    e = '{1'b1, 0, 16, 0, 0};   run(0, 1, 16, 0, -1, -1, -1, e);
    // q inverted at compare index 5 (cycle 6).
    e = '{1'b0, 1, 16, 5, 1};   run(0, 1, 16, 0, 6, -1, -1, e);
    // Restart from DONE; start pulsed mid-CHECK is ignored.
    e = '{1'b1, 0, 16, 0, 0};   run(0, 1, 16, 0, -1, -1, 6, e);
    // d=1, dut_rst in cycles 8..11: honoured, then ignored (compare idx 8..11 fail).
    ign0 = 1'b0;
    e = '{1'b1, 0, 16, 0, 0};   run(0, 1, 16, 1, -1, 8, -1, e);
    ign0 = 1'b1;
    e = '{1'b0, 4, 16, 8, 4};   run(0, 1, 16, 1, -1, 8, -1, e);
    ign0 = 1'b0;

    // Checker reset in the middle of CHECK.
    start_v[0] = 1'b1; d_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_zero(0, "mid-run rst");
    tick();
    @(negedge clk);
    chk("rst stays idle busy", 32'(busy_v[0]), 0);
    tick();

    // LATENCY=3: matching three-stage DUT, then one-stage DUT with 1100 data.
    three1 = 1'b1;
    e = '{1'b1, 0, 16, 0, 0};   run(1, 3, 16, 2, -1, -1, -1, e);
    three1 = 1'b0;
    e = '{1'b0, 16, 16, 0, 16}; run(1, 3, 16, 3, -1, -1, -1, e);

    // 5-bit counters, every compare failing.
    e = '{1'b0, 20, 20, 0, 20}; run(2, 1, 20, 0, -1, -1, -1, e);
    e = '{1'b0, 31, 31, 0, 31}; run(3, 1, 31, 0, -1, -1, -1, e);

    repeat (3) tick();
    for (int i = 0; i < 4; i++)
      chk($sformatf("inst%0d scoreboard drained", i), 32'(sbq[i].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
